ones_count_datapath: RTL and testbench

- Datapath companion to the counting-ones controller FSM.
- Accepts the controller's load / shift-right / clear commands and holds the operand shift register and the ones counter.
- Returns the zero flag z that the controller uses to end a pass.
- Captures the final count into a result register, presented downstream on a valid/ready handshake.

---
 rtl/ones_count_pkg.sv | 18 +
 rtl/ones_count_datapath_if.sv | 30 +++
 rtl/ones_shifter.sv | 50 +++++
 rtl/ones_count_datapath.sv | 96 +++++++++
 tb/tb_ones_count_datapath.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ones_count_pkg.sv
// Shared widths, the width helper and the shifter command encoding for the ones-count datapath.
// Pure declarations: no latency, no backpressure.
package ones_count_pkg;

    localparam int ONES_W = 8;

    // Counter must be able to hold the value w itself, hence w+1 states.
    function automatic int CW_OF(input int w);
        return $clog2(w + 1);
    endfunction

    typedef enum logic [1:0] {
        SH_HOLD  = 2'd0,
        SH_LOAD  = 2'd1,
        SH_SHIFT = 2'd2
    } sh_op_e;

endpackage

// File: rtl/ones_count_datapath_if.sv
// Command, status and result handshake bundle between the controller/consumer and the datapath.
// Wiring only: no latency; result_valid/result_ready carry the downstream backpressure.
interface ones_count_datapath_if #(
    parameter int W  = ones_count_pkg::ONES_W,
    parameter int CW = ones_count_pkg::CW_OF(W)
);

    logic [W-1:0]  data_in;
    logic          load;
    logic          sr;
    logic          clr;
    logic          z;
    logic [CW-1:0] count;
    logic          busy;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          result_ready;
    logic          overrun;

    modport master (
        output data_in, load, sr, clr, result_ready,
        input  z, count, busy, result, result_valid, overrun
    );

    modport slave (
        input  data_in, load, sr, clr, result_ready,
        output z, count, busy, result, result_valid, overrun
    );

endinterface

// File: rtl/ones_shifter.sv
// Operand shift register (load beats shift) with zero detect and LSB tap.
// One-cycle update; z and lsb are combinational from the register; no backpressure.
module ones_shifter
    import ones_count_pkg::*;
#(
    parameter int W = ONES_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] data_in,
    input  logic         load,
    input  logic         sr,
    output logic         lsb,
    output logic         z
);

    sh_op_e       op;
    logic [W-1:0] shreg;
    logic [W-1:0] shreg_nxt;

    always_comb begin
        op = SH_HOLD;
        if (load) begin
            op = SH_LOAD;
        end else if (sr) begin
            op = SH_SHIFT;
        end
    end

    always_comb begin
        shreg_nxt = shreg;
        case (op)
            SH_LOAD:  shreg_nxt = data_in;
            SH_SHIFT: shreg_nxt = {1'b0, shreg[W-1:1]};
            default:  shreg_nxt = shreg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else begin
            shreg <= shreg_nxt;
        end
    end

    assign z   = (shreg == '0);
    assign lsb = shreg[0];

endmodule

// File: rtl/ones_count_datapath.sv
// Ones-count datapath: operand shifter, ones counter, pass arming and a one-deep result register.
// Capture lands one cycle after armed&z; a capture while the result is unconsumed is dropped and flagged.
module ones_count_datapath
    import ones_count_pkg::*;
#(
    parameter int W  = ONES_W,
    parameter int CW = CW_OF(W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ones_count_datapath_if.slave  bus
);

    logic          lsb;
    logic          armed;
    logic          capture;
    logic          xfer;
    logic          accept;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          overrun;

    ones_shifter #(.W(W)) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (bus.data_in),
        .load    (bus.load),
        .sr      (bus.sr),
        .lsb     (lsb),
        .z       (bus.z)
    );

    // A shift that collides with a load is discarded, so it must not count either.
    always_comb begin
        count_nxt = count;
        if (bus.clr) begin
            count_nxt = '0;
        end else if (bus.sr && !bus.load) begin
            count_nxt = count + {{(CW-1){1'b0}}, lsb};
        end
    end

    assign capture = armed && bus.z && !bus.load;
    assign xfer    = result_valid && bus.result_ready;
    assign accept  = !result_valid || bus.result_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (bus.load) begin
            armed <= 1'b1;
        end else if (capture) begin
            armed <= 1'b0;
        end
    end

    // The captured value is the post-update count so a shift in the capture cycle is included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else if (capture && accept) begin
            result       <= count_nxt;
            result_valid <= 1'b1;
        end else if (xfer) begin
            result_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (bus.clr) begin
            overrun <= 1'b0;
        end else if (capture && !accept) begin
            overrun <= 1'b1;
        end
    end

    assign bus.count        = count;
    assign bus.busy         = armed;
    assign bus.result       = result;
    assign bus.result_valid = result_valid;
    assign bus.overrun      = overrun;

endmodule

// File: tb/tb_ones_count_datapath.sv
// Bench for ones_count_datapath: vector table, directed corner sequences, then random passes
// checked against a popcount-based transaction model.
module tb_ones_count_datapath;

    localparam int W  = 8;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ones_count_datapath_if #(.W(W), .CW(CW)) bus ();

    ones_count_datapath #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [8];

    logic [7:0] m_val, m_loaded;
    logic [3:0] m_cnt, m_res;
    logic       m_armed, m_rv, m_ovr, m_cap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.load = 1'b0;
        bus.sr   = 1'b0;
        bus.clr  = 1'b0;
    endtask

    task automatic start_pass(input logic [7:0] d);
        bus.data_in = d;
        bus.load    = 1'b1;
        bus.clr     = 1'b1;
        bus.sr      = 1'b0;
        step();
        idle();
    endtask

    initial begin
        vecs[0] = '{8'hB2, 4'd4};
        vecs[1] = '{8'hA5, 4'd4};
        vecs[2] = '{8'hFF, 4'd8};
        vecs[3] = '{8'h80, 4'd1};
        vecs[4] = '{8'hC3, 4'd4};
        vecs[5] = '{8'h81, 4'd2};
        vecs[6] = '{8'hF0, 4'd4};
        vecs[7] = '{8'h9F, 4'd6};

        idle();
        bus.data_in      = '0;
        bus.result_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        chk("rst_z", bus.z, 1);
        chk("rst_count", bus.count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rv", bus.result_valid, 0);
        chk("rst_ovr", bus.overrun, 0);
        chk("rst_result", bus.result, 0);

        // zero operand: no shifts needed
        start_pass(8'h00);
        chk("zero_z", bus.z, 1);
        chk("zero_busy", bus.busy, 1);
        chk("zero_rv_early", bus.result_valid, 0);
        step();
        chk("zero_rv", bus.result_valid, 1);
        chk("zero_result", bus.result, 0);
        chk("zero_busy_done", bus.busy, 0);
        step();
        chk("zero_xfer", bus.result_valid, 0);

        // table of full 8-shift passes
        for (int v = 0; v < 8; v++) begin
            start_pass(vecs[v].data);
            bus.sr = 1'b1;
            for (int k = 0; k < 8; k++) begin
                step();
                if (k == 6) chk("tbl_z_early", bus.z, 0);
            end
            chk("tbl_z", bus.z, 1);
            chk("tbl_count", bus.count, vecs[v].exp);
            chk("tbl_busy", bus.busy, 1);
            chk("tbl_rv_early", bus.result_valid, 0);
            bus.sr = 1'b0;
            step();
            chk("tbl_result", bus.result, vecs[v].exp);
            chk("tbl_rv", bus.result_valid, 1);
            chk("tbl_busy_done", bus.busy, 0);
            step();
            chk("tbl_xfer", bus.result_valid, 0);
        end

        // overrun: second capture dropped while result unconsumed
        bus.result_ready = 1'b0;
        start_pass(8'h03);
        bus.sr = 1'b1;
        repeat (2) step();
        bus.sr = 1'b0;
        step();
        chk("ovr_res1", bus.result, 2);
        chk("ovr_rv1", bus.result_valid, 1);
        chk("ovr_flag0", bus.overrun, 0);
        start_pass(8'h01);
        bus.sr = 1'b1;
        step();
        bus.sr = 1'b0;
        step();
        chk("ovr_res2", bus.result, 2);
        chk("ovr_rv2", bus.result_valid, 1);
        chk("ovr_flag1", bus.overrun, 1);
        chk("ovr_busy", bus.busy, 0);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        chk("ovr_clr", bus.overrun, 0);
        chk("ovr_res3", bus.result, 2);
        chk("ovr_rv3", bus.result_valid, 1);
        step();
        chk("ovr_hold", bus.result, 2);
        bus.result_ready = 1'b1;
        step();
        chk("ovr_drain", bus.result_valid, 0);

        // command collisions
        start_pass(8'h07);
        bus.sr = 1'b1;
        repeat (3) step();
        chk("col_count3", bus.count, 3);
        bus.load    = 1'b1;
        bus.data_in = 8'h0F;
        step();
        bus.load = 1'b0;
        chk("col_ld_sr_count", bus.count, 3);
        chk("col_ld_sr_busy", bus.busy, 1);
        chk("col_ld_sr_z", bus.z, 0);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        chk("col_clr_sr", bus.count, 0);
        repeat (3) step();
        chk("col_rest_count", bus.count, 3);
        chk("col_rest_z", bus.z, 1);
        bus.sr = 1'b0;
        step();
        chk("col_result", bus.result, 3);
        chk("col_rv", bus.result_valid, 1);
        step();

        // asynchronous reset mid-pass
        start_pass(8'hA5);
        bus.sr = 1'b1;
        repeat (2) step();
        bus.sr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("amid_count", bus.count, 0);
        chk("amid_z", bus.z, 1);
        chk("amid_busy", bus.busy, 0);
        chk("amid_rv", bus.result_valid, 0);
        chk("amid_ovr", bus.overrun, 0);
        step();
        rst_n = 1'b1;

        // random passes against a popcount model
        m_val = '0; m_loaded = '0; m_cnt = '0; m_res = '0;
        m_armed = 1'b0; m_rv = 1'b0; m_ovr = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bus.result_ready = ($urandom % 3) != 0;
            if (!m_armed ? ($urandom % 2) == 0 : ($urandom % 16) == 0) begin
                bus.load = 1'b1;
                bus.clr  = 1'b1;
                case ($urandom % 8)
                    0:       bus.data_in = 8'h00;
                    1:       bus.data_in = 8'hFF;
                    default: bus.data_in = 8'($urandom);
                endcase
                bus.sr = 1'($urandom % 2);
            end else begin
                bus.load = 1'b0;
                bus.clr  = 1'b0;
                bus.sr   = ($urandom % 4) != 0;
            end

            m_cap = m_armed && (m_val == 0) && !bus.load;
            if (bus.load) begin
                m_val    = bus.data_in;
                m_loaded = bus.data_in;
            end else if (bus.sr) begin
                m_val = m_val / 2;
            end
            m_cnt = 4'($countones(m_loaded) - $countones(m_val));
            if (m_cap) begin
                if (!m_rv || bus.result_ready) begin
                    m_res = m_cnt;
                    m_rv  = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_rv && bus.result_ready) begin
                m_rv = 1'b0;
            end
            if (bus.clr) m_ovr = 1'b0;
            if (bus.load) m_armed = 1'b1;
            else if (m_cap) m_armed = 1'b0;

            step();
            chk("rand", {bus.z, bus.count, bus.busy, bus.result, bus.result_valid, bus.overrun},
                {(m_val == 0), m_cnt, m_armed, m_res, m_rv, m_ovr});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
